rotozoom_addr_gen: RTL and testbench
====================================

ROTOZOOM_ADDR_GEN -- requirements
Module: rotozoom_addr_gen

Interface
REQ-001 Parameter TEX_W, 7: texel index width per axis; texture is 2^TEX_W x 2^TEX_W.
REQ-002 Parameter FRAC_W, 16: fractional bits of u/v accumulators; ACC_W = TEX_W+FRAC_W+1 (extra bit = mirror parity).
REQ-003 Parameter SHIFT, 3: extra right shift on strides (texel magnification 2^SHIFT).
REQ-004 Parameter MIRROR, 0: 0 = wrap addressing, 1 = mirrored-repeat addressing.
REQ-005 Parameter CX, 320 / CY, 240: rotation centre in screen pixels (used only under REQ-029).
REQ-006 clk  in  1  pixel clock; all logic on rising edge.
REQ-007 resetn  in  1  asynchronous active-low reset.
REQ-008 frame_start  in  1  one-cycle pulse; latch per-frame parameters.
REQ-009 cos_val, sin_val  in  16 each  signed Q1.14 rotation terms.
REQ-010 scale  in  16  signed Q2.14 zoom factor.
REQ-011 line_start  in  1  pulse at first active pixel of each line.
REQ-012 pix_en  in  1  high for each active pixel.
REQ-013 busy  out  1  per-frame computation in progress.
REQ-014 tex_u, tex_v  out  TEX_W each  texel address of current pixel.
REQ-015 out_valid  out  1  tex_u/tex_v valid this cycle.

Function
REQ-016 FSM states IDLE, CALC_STRIDE, CALC_START, READY; frame_start from any state -> CALC_STRIDE next cycle (restart, in-flight work discarded).
REQ-017 CALC_STRIDE: du = (scale*cos_val) >>> (28-FRAC_W+SHIFT), dv = (scale*sin_val) >>> (28-FRAC_W+SHIFT), 32-bit signed product, truncated to ACC_W bits; inputs sampled on the frame_start cycle.
REQ-018 CALC_START: row-start registers us, vs loaded per REQ-029/030; next state READY.
REQ-019 busy = 1 in CALC_STRIDE and CALC_START, else 0; frame_start -> READY takes exactly 2 cycles.
REQ-020 In READY, line_start: u <= us, v <= vs; us <= us - dv; vs <= vs + du.
REQ-021 In READY, pix_en without line_start: u <= u + du, v <= v + dv.
REQ-022 line_start and pix_en same cycle: line_start action applies; emitted texel is the new row start (us, vs).
REQ-023 Outputs registered, latency 1: out_valid(t+1) = pix_en(t) in READY; tex from value of u/v used for that pixel.
REQ-024 Texel index: t = acc[TEX_W+FRAC_W-1:FRAC_W]; MIRROR=0 -> t; MIRROR=1 -> ~t when acc[ACC_W-1]=1, else t.
REQ-025 All accumulators wrap modulo 2^ACC_W, two's complement; no saturation.
REQ-026 line_start/pix_en outside READY ignored: accumulators hold, out_valid = 0.
REQ-027 tex_u/tex_v hold last value when out_valid = 0.

Reset
REQ-028 resetn low: state IDLE, busy 0, out_valid 0, tex_u/tex_v 0, du/dv/u/v/us/vs 0; takes effect immediately, also mid-calculation or mid-line; release needs frame_start before output.

Configuration
REQ-029 ROTOZOOM_CENTRE_EN defined: CALC_START sets us = CY*dv - CX*du, vs = -(CX*dv) - CY*du (truncated to ACC_W), so screen pixel (CX,CY) maps to texel (0,0).
REQ-030 ROTOZOOM_CENTRE_EN undefined: CALC_START sets us = vs = 0 (rotation about screen origin); CX/CY unused; FSM timing unchanged.

Verification
REQ-031 scale=0x4000, cos=0x4000, sin=0, FRAC_W=16, SHIFT=3, macro off: frame_start, line_start+4 pix_en -> tex_u 0,0,0,0 (du=0x2000), 8th pixel tex_u=1, tex_v=0 throughout.
REQ-032 Same setup, 3 lines of 1 pixel -> tex_v per line 0,0,0; set sin=0x4000, cos=0 -> line k row start u = -k*0x2000, tex_u of line 1 = 127 (wrap).
REQ-033 MIRROR=1, u crossing 2^(TEX_W+FRAC_W) -> tex_u sequence ...126,127,127,126... (mirror fold).
REQ-034 frame_start reasserted in CALC_START -> busy stays high 2 further cycles; pix_en during busy -> out_valid 0.
REQ-035 Macro on, scale=0x4000, cos=0x4000, sin=0: pixel at column 320, line 240 -> tex_u = tex_v = 0.
REQ-036 resetn pulsed low mid-line -> out_valid, busy, tex_u, tex_v 0 same cycle; pix_en ignored until frame_start + 2 cycles.

Source files
------------

// File: rtl/rotozoom_addr_gen.sv
// Rotozoom texel address generator: per-frame stride/row-start setup, then per-pixel u/v stepping.
// Optional `ROTOZOOM_CENTRE_EN moves the rotation centre to screen pixel (CX,CY).
module rotozoom_addr_gen #(
   parameter int TEX_W  = 7,
   parameter int FRAC_W = 16,
   parameter int SHIFT  = 3,
   parameter int MIRROR = 0,
   parameter int CX     = 320,
   parameter int CY     = 240
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               frame_start,
   input  logic signed [15:0] cos_val,
   input  logic signed [15:0] sin_val,
   input  logic signed [15:0] scale,
   input  logic               line_start,
   input  logic               pix_en,
   output logic               busy,
   output logic [TEX_W-1:0]   tex_u,
   output logic [TEX_W-1:0]   tex_v,
   output logic               out_valid
);
   localparam int ACC_W = TEX_W + FRAC_W + 1;
   localparam int PSH   = 28 - FRAC_W + SHIFT;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      CALC_STRIDE = 2'd1,
      CALC_START  = 2'd2,
      READY       = 2'd3
   } state_t;

   state_t state_q, state_d;
   logic signed [15:0] cos_q, cos_d, sin_q, sin_d, scale_q, scale_d;
   logic [ACC_W-1:0]   du_q, du_d, dv_q, dv_d;
   logic [ACC_W-1:0]   u_q, u_d, v_q, v_d, us_q, us_d, vs_q, vs_d;
   logic [TEX_W-1:0]   tex_u_q, tex_u_d, tex_v_q, tex_v_d;
   logic               valid_q, valid_d;
   logic signed [31:0] prod_u_s, prod_v_s;

   // Texel index from an accumulator; the top bit selects the mirrored half when enabled.
   function automatic logic [TEX_W-1:0] texel(input logic [ACC_W-1:0] acc);
      logic [TEX_W-1:0] t;
      t = acc[TEX_W+FRAC_W-1:FRAC_W];
      if ((MIRROR != 0) && acc[ACC_W-1]) begin
         texel = ~t;
      end else begin
         texel = t;
      end
   endfunction

   assign prod_u_s = $signed({{16{scale_q[15]}}, scale_q}) * $signed({{16{cos_q[15]}}, cos_q});
   assign prod_v_s = $signed({{16{scale_q[15]}}, scale_q}) * $signed({{16{sin_q[15]}}, sin_q});

   // Next-state, stride/row-start setup and per-pixel accumulator stepping.
   always_comb begin
      state_d = state_q;
      cos_d   = cos_q;
      sin_d   = sin_q;
      scale_d = scale_q;
      du_d    = du_q;
      dv_d    = dv_q;
      u_d     = u_q;
      v_d     = v_q;
      us_d    = us_q;
      vs_d    = vs_q;
      tex_u_d = tex_u_q;
      tex_v_d = tex_v_q;
      valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = IDLE;
         end
         CALC_STRIDE: begin
            du_d    = ACC_W'(prod_u_s >>> PSH);
            dv_d    = ACC_W'(prod_v_s >>> PSH);
            state_d = CALC_START;
         end
         CALC_START: begin
`ifdef ROTOZOOM_CENTRE_EN
            us_d = ACC_W'(CY) * dv_q - ACC_W'(CX) * du_q;
            vs_d = -(ACC_W'(CX) * dv_q) - ACC_W'(CY) * du_q;
`else
            us_d = {ACC_W{1'b0}};
            vs_d = {ACC_W{1'b0}};
`endif
            state_d = READY;
         end
         READY: begin
            if (line_start) begin
               u_d  = us_q;
               v_d  = vs_q;
               us_d = us_q - dv_q;
               vs_d = vs_q + du_q;
            end else if (pix_en) begin
               u_d = u_q + du_q;
               v_d = v_q + dv_q;
            end else begin
               u_d = u_q;
               v_d = v_q;
            end
            // The emitted texel is the accumulator value after this pixel's update.
            if (pix_en) begin
               valid_d = 1'b1;
               tex_u_d = texel(u_d);
               tex_v_d = texel(v_d);
            end else begin
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (frame_start) begin
         state_d = CALC_STRIDE;
         cos_d   = cos_val;
         sin_d   = sin_val;
         scale_d = scale;
      end else begin
         cos_d   = cos_d;
      end
   end

   // State, parameter and accumulator registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cos_q   <= 16'sd0;
         sin_q   <= 16'sd0;
         scale_q <= 16'sd0;
         du_q    <= {ACC_W{1'b0}};
         dv_q    <= {ACC_W{1'b0}};
         u_q     <= {ACC_W{1'b0}};
         v_q     <= {ACC_W{1'b0}};
         us_q    <= {ACC_W{1'b0}};
         vs_q    <= {ACC_W{1'b0}};
         tex_u_q <= {TEX_W{1'b0}};
         tex_v_q <= {TEX_W{1'b0}};
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cos_q   <= cos_d;
         sin_q   <= sin_d;
         scale_q <= scale_d;
         du_q    <= du_d;
         dv_q    <= dv_d;
         u_q     <= u_d;
         v_q     <= v_d;
         us_q    <= us_d;
         vs_q    <= vs_d;
         tex_u_q <= tex_u_d;
         tex_v_q <= tex_v_d;
         valid_q <= valid_d;
      end
   end

   assign busy      = (state_q == CALC_STRIDE) || (state_q == CALC_START);
   assign tex_u     = tex_u_q;
   assign tex_v     = tex_v_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_rotozoom_addr_gen.sv
// Randomized scoreboard bench for rotozoom_addr_gen (wrap and mirror instances side by side).
// The reference model computes each texel in closed form from frame parameters, line index and column.
module tb_rotozoom_addr_gen;
   logic clk = 1'b0;
   logic resetn;
   logic frame_start, line_start, pix_en;
   logic signed [15:0] cos_val, sin_val, scale;
   logic busy0, busy1, out_valid0, out_valid1;
   logic [6:0] tex_u0, tex_v0, tex_u1, tex_v1;

   always #5 clk = ~clk;

   rotozoom_addr_gen #(.MIRROR(0)) dut (
      .clk(clk), .resetn(resetn), .frame_start(frame_start),
      .cos_val(cos_val), .sin_val(sin_val), .scale(scale),
      .line_start(line_start), .pix_en(pix_en),
      .busy(busy0), .tex_u(tex_u0), .tex_v(tex_v0), .out_valid(out_valid0)
   );

   rotozoom_addr_gen #(.MIRROR(1)) dut_m (
      .clk(clk), .resetn(resetn), .frame_start(frame_start),
      .cos_val(cos_val), .sin_val(sin_val), .scale(scale),
      .line_start(line_start), .pix_en(pix_en),
      .busy(busy1), .tex_u(tex_u1), .tex_v(tex_v1), .out_valid(out_valid1)
   );

   typedef struct packed {
      logic [6:0] u0;
      logic [6:0] v0;
      logic [6:0] u1;
      logic [6:0] v1;
   } exp_t;

   exp_t expq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // reference model state
   bit         m_started = 1'b0;
   int         m_busy_left = 0;
   bit         m_exp_valid = 1'b0;
   logic [23:0] m_du = 24'd0, m_dv = 24'd0, m_us0 = 24'd0, m_vs0 = 24'd0;
   int         m_line = 0, m_line_next = 0, m_col = 0;
   logic [6:0] last_u0 = 7'd0, last_v0 = 7'd0, last_u1 = 7'd0, last_v1 = 7'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] tex_of(input logic [23:0] a, input bit mir);
      logic [6:0] t;
      t = a[22:16];
      return (mir && a[23]) ? ~t : t;
   endfunction

   // Model update for one rising edge, using the inputs that edge samples.
   task automatic model_edge(input logic fs, input logic ls, input logic pe);
      bit          ready;
      logic [23:0] u, v;
      logic signed [31:0] p;
      exp_t        e;
      ready       = m_started && (m_busy_left == 0);
      m_exp_valid = 1'b0;
      if (ready) begin
         if (ls) begin
            m_line = m_line_next;
            m_line_next++;
            m_col = 0;
         end else if (pe) begin
            m_col++;
         end
         if (pe) begin
            u = m_us0 - 24'(m_line) * m_dv + 24'(m_col) * m_du;
            v = m_vs0 + 24'(m_line) * m_du + 24'(m_col) * m_dv;
            e.u0 = tex_of(u, 1'b0);
            e.v0 = tex_of(v, 1'b0);
            e.u1 = tex_of(u, 1'b1);
            e.v1 = tex_of(v, 1'b1);
            expq.push_back(e);
            m_exp_valid = 1'b1;
         end
      end
      if (m_busy_left > 0) m_busy_left--;
      if (fs) begin
         p = 32'(int'(scale) * int'(cos_val));
         p = p >>> 15;
         m_du = p[23:0];
         p = 32'(int'(scale) * int'(sin_val));
         p = p >>> 15;
         m_dv = p[23:0];
`ifdef ROTOZOOM_CENTRE_EN
         m_us0 = 24'(240) * m_dv - 24'(320) * m_du;
         m_vs0 = 24'd0 - 24'(320) * m_dv - 24'(240) * m_du;
`else
         m_us0 = 24'd0;
         m_vs0 = 24'd0;
`endif
         m_busy_left = 2;
         m_started   = 1'b1;
         m_line_next = 0;
      end
   endtask

   task automatic cyc(input logic fs, input logic ls, input logic pe);
      frame_start = fs;
      line_start  = ls;
      pix_en      = pe;
      @(posedge clk);
      if (resetn) model_edge(fs, ls, pe);
      #1;
      frame_start = 1'b0;
      line_start  = 1'b0;
      pix_en      = 1'b0;
   endtask

   task automatic set_frame(input logic [15:0] c, input logic [15:0] s, input logic [15:0] sc);
      cos_val = c;
      sin_val = s;
      scale   = sc;
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a texel.
   always @(negedge clk) begin
      exp_t e;
      chk("busy", busy0, m_busy_left > 0);
      chk("busy_m", busy1, m_busy_left > 0);
      chk("out_valid", out_valid0, m_exp_valid);
      chk("out_valid_m", out_valid1, m_exp_valid);
      if (out_valid0) begin
         chk("sb_nonempty", expq.size() != 0, 1);
         if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("tex_u", tex_u0, e.u0);
            chk("tex_v", tex_v0, e.v0);
            chk("tex_u_mirror", tex_u1, e.u1);
            chk("tex_v_mirror", tex_v1, e.v1);
            last_u0 = e.u0; last_v0 = e.v0; last_u1 = e.u1; last_v1 = e.v1;
         end
      end else begin
         chk("hold_u", tex_u0, last_u0);
         chk("hold_v", tex_v0, last_v0);
         chk("hold_u_mirror", tex_u1, last_u1);
         chk("hold_v_mirror", tex_v1, last_v1);
      end
   end

   initial begin
      resetn = 1'b0;
      frame_start = 1'b0; line_start = 1'b0; pix_en = 1'b0;
      set_frame(16'h0000, 16'h0000, 16'h0000);
      #12;
      chk("reset_busy", busy0, 0);
      chk("reset_valid", out_valid0, 0);
      chk("reset_tex_u", tex_u0, 0);
      chk("reset_tex_v", tex_v0, 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      cyc(1'b0, 1'b1, 1'b1);   // ignored before any frame_start

      // unit stride along u: du = 1/8 texel
      set_frame(16'h4000, 16'h0000, 16'h4000);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);   // pixel during busy is ignored
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, 1'b0, 1'b1);
         if (i == 4) chk("u_step_px4", tex_u0, 0);
         if (i == 8) chk("u_step_px8", tex_u0, 1);
      end

      // rotation by 90 degrees: row starts walk backwards in u and wrap
      set_frame(16'h0000, 16'h4000, 16'h4000);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 1'b1, 1'b1);
         if (k == 1) chk("row_wrap_u", tex_u0, 127);
         chk("row_v", tex_v0, 0);
      end

      // restart while in CALC_START keeps busy for two more cycles
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      chk("restart_busy1", busy0, 1);
      cyc(1'b0, 1'b0, 1'b1);
      chk("restart_busy2", busy0, 1);
      cyc(1'b0, 1'b0, 1'b0);
      chk("restart_ready", busy0, 0);

      // long line crossing the mirror boundary
      set_frame(16'h7FFF, 16'h0000, 16'h7FFF);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 300; i++) begin
         cyc(1'b0, 1'b0, 1'b1);
         if (i == 256) chk("mirror_pre", tex_u1, 127);
         if (i == 257) chk("mirror_fold", tex_u1, 127);
         if (i == 259) chk("mirror_post", tex_u1, 126);
         if (i == 259) chk("wrap_post", tex_u0, 1);
      end

      // randomized frames
      for (int f = 0; f < 12; f++) begin
         set_frame(16'($urandom), 16'($urandom), 16'($urandom));
         cyc(1'b1, 1'b0, 1'b0);
         cyc(1'b0, 1'($urandom), 1'($urandom));
         cyc(1'b0, 1'($urandom), 1'($urandom));
         for (int l = 0; l < int'($urandom_range(3, 6)); l++) begin
            cyc(1'b0, 1'b1, 1'($urandom));
            for (int p = 0; p < int'($urandom_range(0, 40)); p++)
               cyc(1'b0, 1'b0, $urandom_range(0, 9) < 7);
         end
      end

      // asynchronous reset in the middle of a line
      set_frame(16'h7FFF, 16'h2000, 16'h7FFF);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b1);
      pix_en = 1'b1;
      #2;
      resetn = 1'b0;
      #1;
      chk("rst_valid", out_valid0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_tex_u", tex_u0, 0);
      chk("rst_tex_v", tex_v0, 0);
      m_started = 1'b0; m_busy_left = 0; m_exp_valid = 1'b0;
      expq.delete();
      last_u0 = 7'd0; last_v0 = 7'd0; last_u1 = 7'd0; last_v1 = 7'd0;
      @(posedge clk); #1;
      pix_en = 1'b0;
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'(i == 0), 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1);

`ifdef ROTOZOOM_CENTRE_EN
      // screen pixel (320,240) lands on texel (0,0)
      set_frame(16'h4000, 16'h0000, 16'h4000);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 240; k++) cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 320; i++) cyc(1'b0, 1'b0, 1'b1);
      chk("centre_u", tex_u0, 0);
      chk("centre_v", tex_v0, 0);
`endif

      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
      chk("sb_drained", expq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
